// File: rtl/fetch_unit.sv
// Instruction fetch / PC unit: owns the PC, reads the instruction ROM and hands a
// registered instruction plus valid flag to the decoder. Optional counters: FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter int              INSTR_W    = 9,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stall,
    input  logic               BranchEn,
    input  logic               BrCond,
    input  logic [PC_W-1:0]    Target,
    input  logic               Ack,
    output logic [PC_W-1:0]    RomAddr,
    input  logic [INSTR_W-1:0] RomData,
    output logic [INSTR_W-1:0] Instruction,
    output logic               InstrValid,
    output logic [PC_W-1:0]    InstrPC,
    output logic               Done
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        CycleCnt,
    output logic [15:0]        TakenCnt,
    output logic [15:0]        BubbleCnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t             state_reg, state_next;
    logic [PC_W-1:0]    pc_reg, pc_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [PC_W-1:0]    ipc_reg, ipc_next;
    logic               valid_reg, valid_next;
    logic               squash_reg, squash_next;
    logic               done_reg, done_next;
    logic               taken, ack_hit, clear_cnt, run_adv;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg  <= IDLE;
            pc_reg     <= START_ADDR;
            instr_reg  <= '0;
            ipc_reg    <= '0;
            valid_reg  <= 1'b0;
            squash_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            instr_reg  <= instr_next;
            ipc_reg    <= ipc_next;
            valid_reg  <= valid_next;
            squash_reg <= squash_next;
            done_reg   <= done_next;
        end
    end

    // squash_reg marks that the word now held in Instruction is the bubble behind a taken branch
    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        instr_next  = instr_reg;
        ipc_next    = ipc_reg;
        valid_next  = valid_reg;
        squash_next = squash_reg;
        done_next   = done_reg;
        clear_cnt   = 1'b0;
        run_adv     = 1'b0;
        taken       = valid_reg & BranchEn & BrCond;
        ack_hit     = valid_reg & Ack;
        case (state_reg)
            IDLE, HALT: begin
                if (Start) begin
                    state_next  = RUN;
                    pc_next     = START_ADDR;
                    valid_next  = 1'b0;
                    squash_next = 1'b0;
                    done_next   = 1'b0;
                    clear_cnt   = 1'b1;
                end
            end
            RUN: begin
                if (!Stall) begin
                    run_adv = 1'b1;
                    if (ack_hit) begin
                        // Ack beats a simultaneous taken branch; PC stays put
                        state_next  = HALT;
                        done_next   = 1'b1;
                        valid_next  = 1'b0;
                        squash_next = 1'b0;
                    end else begin
                        instr_next  = RomData;
                        ipc_next    = pc_reg;
                        valid_next  = ~taken;
                        squash_next = taken;
                        pc_next     = taken ? Target : pc_reg + PC_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign RomAddr     = pc_reg;
    assign Instruction = instr_reg;
    assign InstrValid  = valid_reg;
    assign InstrPC     = ipc_reg;
    assign Done        = done_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cycle_cnt_reg, taken_cnt_reg, bubble_cnt_reg;
    logic        taken_fire;

    assign taken_fire = run_adv & taken & ~ack_hit;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cycle_cnt_reg  <= '0;
            taken_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else if (clear_cnt) begin
            cycle_cnt_reg  <= '0;
            taken_cnt_reg  <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (run_adv && cycle_cnt_reg != 16'hFFFF)
                cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
            if (taken_fire && taken_cnt_reg != 16'hFFFF)
                taken_cnt_reg <= taken_cnt_reg + 16'd1;
            // each taken branch loads exactly one squashed word
            if (taken_fire && bubble_cnt_reg != 16'hFFFF)
                bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
        end
    end

    assign CycleCnt  = cycle_cnt_reg;
    assign TakenCnt  = taken_cnt_reg;
    assign BubbleCnt = bubble_cnt_reg;
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clear_cnt, run_adv, squash_reg};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start-up latency, branches, stall, ack/halt, PC wrap, async reset.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;

    logic               Clk;
    logic               Reset;
    logic               Start;
    logic               Stall;
    logic               BranchEn;
    logic               BrCond;
    logic [PC_W-1:0]    Target;
    logic               Ack;
    logic [PC_W-1:0]    RomAddr;
    logic [INSTR_W-1:0] RomData;
    logic [INSTR_W-1:0] Instruction;
    logic               InstrValid;
    logic [PC_W-1:0]    InstrPC;
    logic               Done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]        CycleCnt, TakenCnt, BubbleCnt;
`endif

    logic [INSTR_W-1:0] rom [0:(1<<PC_W)-1];
    int total = 0;
    int bad   = 0;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .START_ADDR('0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .BrCond(BrCond), .Target(Target), .Ack(Ack),
        .RomAddr(RomAddr), .RomData(RomData), .Instruction(Instruction),
        .InstrValid(InstrValid), .InstrPC(InstrPC), .Done(Done)
`ifdef FETCH_PERF_CNT_EN
        , .CycleCnt(CycleCnt), .TakenCnt(TakenCnt), .BubbleCnt(BubbleCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign RomData = rom[RomAddr];

    function automatic logic [INSTR_W-1:0] word_at(input int a);
        return INSTR_W'(a * 37 + 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_instr(input string tag, input int pc, input int raddr);
        check({tag, " valid"}, 32'(InstrValid), 32'd1);
        check({tag, " pc"},    32'(InstrPC),    32'(pc));
        check({tag, " instr"}, 32'(Instruction), 32'(word_at(pc)));
        check({tag, " raddr"}, 32'(RomAddr),    32'(raddr));
        $display("t=%0t %s: InstrPC=%0d Instr=%0h RomAddr=%0d", $time, tag, InstrPC, Instruction, RomAddr);
    endtask

    task automatic chk_bubble(input string tag, input int raddr);
        check({tag, " valid"}, 32'(InstrValid), 32'd0);
        check({tag, " raddr"}, 32'(RomAddr),    32'(raddr));
        $display("t=%0t %s: bubble RomAddr=%0d", $time, tag, RomAddr);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " valid"}, 32'(InstrValid),  32'd0);
        check({tag, " done"},  32'(Done),        32'd0);
        check({tag, " raddr"}, 32'(RomAddr),     32'd0);
        check({tag, " pc"},    32'(InstrPC),     32'd0);
        check({tag, " instr"}, 32'(Instruction), 32'd0);
        $display("t=%0t %s: reset values checked", $time, tag);
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = word_at(i);
        Reset = 1'b0; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
        BrCond = 1'b0; Target = '0; Ack = 1'b0;
        #3;
        chk_reset("reset");
        tick();
        Reset = 1'b1;
        tick();
        check("idle valid", 32'(InstrValid), 32'd0);

        // start-up: RomAddr=0 next cycle, first valid word the cycle after
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_bubble("start n+1", 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_instr("seq", k, k + 1);
        end

        // taken branch at PC 5 -> 20 with one bubble
        BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd20;
        tick();
        BranchEn = 1'b0; BrCond = 1'b0;
        chk_bubble("br5 bubble", 20);
        tick();
        chk_instr("br5 target", 20, 21);

        // jump back to 5, then a not-taken branch there
        BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd5;
        tick();
        BranchEn = 1'b0; BrCond = 1'b0;
        chk_bubble("back bubble", 5);
        tick();
        chk_instr("back target", 5, 6);
        BranchEn = 1'b1; BrCond = 1'b0;
        tick();
        BranchEn = 1'b0;
        chk_instr("not taken", 6, 7);
        tick();
        tick();
        chk_instr("reach 8", 8, 9);

        // branch at PC 8 presented under a 3-cycle stall
        Stall = 1'b1; BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd40;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_instr("stall hold", 8, 9);
        end
        Stall = 1'b0;
        tick();
        BranchEn = 1'b0; BrCond = 1'b0;
        chk_bubble("stall bubble", 40);
        tick();
        chk_instr("stall target", 40, 41);

        // get to PC 12, then Ack together with a taken branch
        BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd12;
        tick();
        BranchEn = 1'b0; BrCond = 1'b0;
        chk_bubble("to12 bubble", 12);
        tick();
        chk_instr("at 12", 12, 13);
        Ack = 1'b1; BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd100;
        tick();
        Ack = 1'b0; BranchEn = 1'b0; BrCond = 1'b0;
        check("ack done", 32'(Done), 32'd1);
        chk_bubble("ack halt", 13);
        tick();
        check("halt held", 32'(Done), 32'd1);
        chk_bubble("halt frozen", 13);

        // restart from HALT with Stall also high: Start wins
        Start = 1'b1; Stall = 1'b1;
        tick();
        Start = 1'b0; Stall = 1'b0;
        check("restart done", 32'(Done), 32'd0);
        chk_bubble("restart n+1", 0);
        tick();
        chk_instr("restart first", 0, 1);

        // wrap from the top of the address space
        BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd1023;
        tick();
        BranchEn = 1'b0; BrCond = 1'b0;
        chk_bubble("wrap bubble", 1023);
        tick();
        chk_instr("wrap top", 1023, 0);
        tick();
        chk_instr("wrap zero", 0, 1);

        // Start while running is ignored
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk_instr("start in run", 1, 2);

        // branch to own address: one bubble per iteration
        BranchEn = 1'b1; BrCond = 1'b1; Target = 10'd1;
        tick();
        chk_bubble("self bubble1", 1);
        tick();
        chk_instr("self loop", 1, 2);
        tick();
        BranchEn = 1'b0; BrCond = 1'b0;
        chk_bubble("self bubble2", 1);
        tick();
        chk_instr("self again", 1, 2);

        // asynchronous reset mid-run, checked without a clock edge
        #1;
        Reset = 1'b0;
        #1;
        chk_reset("async reset");
        #20;
        chk_reset("reset held");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
